// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link constants
// common to BaudRateGen, uart_rx and the future uart_tx.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input.
// Resets to 1 so an idle-high serial line is seen as idle out of reset.
// Ports: Clock, Reset_n (async active-low), i_d (async in), o_q (synchronized out).
module sync_2ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift chain; stage 0 takes the raw input.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive deserializer: samples Rx at mid-bit using the OVERSAMPLE x baud
// tick, assembles LSB-first frames and presents each byte with a one-cycle
// DataValid strobe. A low stop bit gives one FramingError and the receiver then
// waits for the line to return high.
// Optional macro UART_RX_PARITY_EN: adds an even-parity bit and ParityError.
// Ports: Clock, Reset_n (async active-low), OversampleTick, Rx (async serial in),
//        Data, DataValid, FramingError, [ParityError], Busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 OversampleTick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 DataValid,
  output logic                 FramingError,
`ifdef UART_RX_PARITY_EN
  output logic                 ParityError,
`endif
  output logic                 Busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  rx_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]     r_bitcnt, w_bitcnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 r_busy;
  logic                 w_rxs;
  logic                 w_half, w_last;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par_nxt;
  logic                 r_perr, w_perr_nxt;
`endif

  sync_2ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .i_d     (Rx),
    .o_q     (w_rxs)
  );

  assign w_half = OversampleTick && (r_cnt == CNT_HALF);
  assign w_last = OversampleTick && (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; all sampling decisions happen on tick cycles only.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (!w_rxs) w_state_nxt = START;
      START:  if (w_half) w_state_nxt = w_rxs ? IDLE : DATA;
      DATA:   if (w_last && (r_bitcnt == BIT_LAST))
`ifdef UART_RX_PARITY_EN
                w_state_nxt = PARITY;
      PARITY: if (w_last) w_state_nxt = STOP;
`else
                w_state_nxt = STOP;
`endif
      STOP:   if (w_last) w_state_nxt = w_rxs ? IDLE : BREAK;
      BREAK:  if (w_rxs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath next values and strobes.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt    = r_par;
    w_perr_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: w_cnt_nxt = '0;
      START: begin
        if (w_half) begin
          w_cnt_nxt    = '0;
          w_bitcnt_nxt = '0;
        end else if (OversampleTick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_last) begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          w_shift_nxt  = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_cnt_nxt    = '0;
          w_bitcnt_nxt = r_bitcnt + 1'b1;
        end else if (OversampleTick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_last) begin
          w_par_nxt = w_rxs;
          w_cnt_nxt = '0;
        end else if (OversampleTick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            w_perr_nxt  = (^r_shift) ^ r_par;
`endif
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else if (OversampleTick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BREAK: w_cnt_nxt = '0;
      default: w_cnt_nxt = '0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
`endif
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_ferr   <= w_ferr_nxt;
      r_busy   <= (w_state_nxt != IDLE);
`ifdef UART_RX_PARITY_EN
      r_par    <= w_par_nxt;
      r_perr   <= w_perr_nxt;
`endif
    end
  end

  assign Data         = r_data;
  assign DataValid    = r_valid;
  assign FramingError = r_ferr;
  assign Busy         = r_busy;
`ifdef UART_RX_PARITY_EN
  assign ParityError  = r_perr;
`endif

endmodule
